// File: rtl/axi_read_arbiter_if.sv
// rtl/axi_read_arbiter_if.sv - AXI3 read address/data channel bundle shared by requesters and bus
interface axi_read_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arlen, arsize, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - round-robin scheduler sharing one AXI3 read port between dcache and icache
module axi_read_arbiter #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  axi_read_arbiter_if.slave  s0,
  axi_read_arbiter_if.slave  s1,
  axi_read_arbiter_if.master m,
  output logic [ID_W-1:0]    m_arid,
  output logic [1:0]         m_arburst,
  output logic [1:0]         m_arlock,
  output logic [3:0]         m_arcache,
  output logic [2:0]         m_arprot,
  input  logic [ID_W-1:0]    m_rid
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              grant;
  logic              last;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        len_q;
  logic [2:0]        size_q;
  logic              any_req;
  logic              pick;
  logic              sel_rready;
  logic              burst_done;
  logic [DATA_W-1:0] beat_data;
  logic              unused_rid;

  assign any_req    = s0.arvalid | s1.arvalid;
  // A lone requester wins outright; when both ask, the one that did not win last time goes next.
  assign pick       = s1.arvalid & (~s0.arvalid | ~last);
  assign sel_rready = grant ? s1.rready : s0.rready;
  assign burst_done = m.rvalid & sel_rready & m.rlast;
  assign beat_data  = m.rdata;
  // Only one burst is ever outstanding, so the returned ID carries no routing information.
  assign unused_rid = ^m_rid;

  // State register; reset aborts any burst and returns to IDLE immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: grant in IDLE, address handshake in ADDR, last beat handshake in DATA.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ADDR;
      ADDR:    if (m.arready) state_next = DATA;
      DATA:    if (burst_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant, round-robin history and latched request payload, captured when IDLE grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant  <= 1'b0;
      last   <= 1'b1;
      addr_q <= '0;
      len_q  <= '0;
      size_q <= '0;
    end else if (state == IDLE && any_req) begin
      grant  <= pick;
      last   <= pick;
      addr_q <= pick ? s1.araddr : s0.araddr;
      len_q  <= pick ? s1.arlen  : s0.arlen;
      size_q <= pick ? s1.arsize : s0.arsize;
    end
  end

  // Output routing: AR handshake and R beats pass combinationally to/from the granted port only.
  always_comb begin
    m.arvalid  = 1'b0;
    m.rready   = 1'b0;
    s0.arready = 1'b0;
    s1.arready = 1'b0;
    s0.rvalid  = 1'b0;
    s0.rdata   = '0;
    s0.rresp   = '0;
    s0.rlast   = 1'b0;
    s1.rvalid  = 1'b0;
    s1.rdata   = '0;
    s1.rresp   = '0;
    s1.rlast   = 1'b0;
    case (state)
      ADDR: begin
        m.arvalid = 1'b1;
        if (grant) s1.arready = m.arready;
        else       s0.arready = m.arready;
      end
      DATA: begin
        m.rready = sel_rready;
        if (grant) begin
          s1.rvalid = m.rvalid;
          s1.rdata  = beat_data;
          s1.rresp  = m.rresp;
          s1.rlast  = m.rlast;
        end else begin
          s0.rvalid = m.rvalid;
          s0.rdata  = beat_data;
          s0.rresp  = m.rresp;
          s0.rlast  = m.rlast;
        end
      end
      default: ;
    endcase
  end

  assign m.araddr  = addr_q;
  assign m.arlen   = len_q;
  assign m.arsize  = size_q;
  assign m_arid    = {{(ID_W-1){1'b0}}, grant};
  assign m_arburst = 2'b01;
  assign m_arlock  = 2'b00;
  assign m_arcache = 4'b0000;
  assign m_arprot  = 3'b000;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - randomized and directed checks of the dcache/icache read arbiter
module tb_axi_read_arbiter;
  logic       clk;
  logic       rst;
  logic [3:0] m_arid;
  logic [3:0] m_rid;
  logic [1:0] m_arburst;
  logic [1:0] m_arlock;
  logic [3:0] m_arcache;
  logic [2:0] m_arprot;
  int         n_checks;
  int         n_fail;

  axi_read_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s0_if ();
  axi_read_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s1_if ();
  axi_read_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m_if ();

  axi_read_arbiter #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .s0(s0_if), .s1(s1_if), .m(m_if),
    .m_arid(m_arid), .m_arburst(m_arburst), .m_arlock(m_arlock),
    .m_arcache(m_arcache), .m_arprot(m_arprot), .m_rid(m_rid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(int p, logic v, logic [31:0] a, logic [3:0] l, logic [2:0] sz);
    if (p == 0) begin
      s0_if.arvalid = v; s0_if.araddr = a; s0_if.arlen = l; s0_if.arsize = sz;
    end else begin
      s1_if.arvalid = v; s1_if.araddr = a; s1_if.arlen = l; s1_if.arsize = sz;
    end
  endtask

  task automatic set_rready(int p, logic v);
    if (p == 0) s0_if.rready = v;
    else        s1_if.rready = v;
  endtask

  task automatic set_beat(logic v, logic [31:0] d, logic l, logic [1:0] r);
    m_if.rvalid = v; m_if.rdata = d; m_if.rlast = l; m_if.rresp = r;
  endtask

  function automatic logic s_arready(int p);
    return (p == 0) ? s0_if.arready : s1_if.arready;
  endfunction
  function automatic logic s_rvalid(int p);
    return (p == 0) ? s0_if.rvalid : s1_if.rvalid;
  endfunction
  function automatic logic [31:0] s_rdata(int p);
    return (p == 0) ? s0_if.rdata : s1_if.rdata;
  endfunction
  function automatic logic s_rlast(int p);
    return (p == 0) ? s0_if.rlast : s1_if.rlast;
  endfunction
  function automatic logic [1:0] s_rresp(int p);
    return (p == 0) ? s0_if.rresp : s1_if.rresp;
  endfunction

  task automatic idle_inputs();
    set_req(0, 1'b0, 32'h0, 4'h0, 3'h0);
    set_req(1, 1'b0, 32'h0, 4'h0, 3'h0);
    set_rready(0, 1'b0);
    set_rready(1, 1'b0);
    set_beat(1'b0, 32'h0, 1'b0, 2'b00);
    m_if.arready = 1'b0;
    m_rid = 4'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic check_all_quiet(string tag);
    n_checks++; if (m_if.arvalid !== 1'b0) begin n_fail++; $display("FAIL %s_m_arvalid: got %b want 0", tag, m_if.arvalid); end
    n_checks++; if (m_if.rready !== 1'b0) begin n_fail++; $display("FAIL %s_m_rready: got %b want 0", tag, m_if.rready); end
    n_checks++; if ({s0_if.arready, s1_if.arready} !== 2'b00) begin n_fail++; $display("FAIL %s_arready: got %b want 00", tag, {s0_if.arready, s1_if.arready}); end
    n_checks++; if ({s0_if.rvalid, s1_if.rvalid} !== 2'b00) begin n_fail++; $display("FAIL %s_rvalid: got %b want 00", tag, {s0_if.rvalid, s1_if.rvalid}); end
    n_checks++; if ({s0_if.rdata, s1_if.rdata} !== 64'h0) begin n_fail++; $display("FAIL %s_rdata: got %h want 0", tag, {s0_if.rdata, s1_if.rdata}); end
  endtask

  // Wait (bounded) for m_arvalid, check payload for port p, complete the handshake, drop the request.
  task automatic wait_ar(int p, logic [31:0] a, logic [3:0] l, output int waited);
    waited = 0;
    settle();
    while (m_if.arvalid !== 1'b1 && waited < 20) begin
      waited++;
      cyc();
      settle();
    end
    n_checks++;
    if (m_if.arvalid !== 1'b1) begin
      n_fail++; $display("FAIL ar_timeout: m_arvalid=%b after %0d cycles, want 1", m_if.arvalid, waited);
    end else begin
      n_checks++; if (m_arid !== 4'(p)) begin n_fail++; $display("FAIL ar_id: got %0d want %0d", m_arid, p); end
      n_checks++; if (m_if.araddr !== a) begin n_fail++; $display("FAIL ar_addr: got %h want %h", m_if.araddr, a); end
      n_checks++; if (m_if.arlen !== l) begin n_fail++; $display("FAIL ar_len: got %0d want %0d", m_if.arlen, l); end
      n_checks++; if (m_arburst !== 2'b01) begin n_fail++; $display("FAIL ar_burst: got %b want 01", m_arburst); end
      m_if.arready = 1'b1;
      settle();
      n_checks++; if (s_arready(p) !== 1'b1) begin n_fail++; $display("FAIL ar_ready_granted: got %b want 1", s_arready(p)); end
      n_checks++; if (s_arready(1 - p) !== 1'b0) begin n_fail++; $display("FAIL ar_ready_other: got %b want 0", s_arready(1 - p)); end
      cyc();
      m_if.arready = 1'b0;
      set_req(p, 1'b0, 32'h0, 4'h0, 3'h0);
    end
  endtask

  // Deliver len+1 beats with no backpressure and check they reach port p only.
  task automatic serve_beats(int p, int len, logic [31:0] base);
    for (int i = 0; i <= len; i++) begin
      set_rready(p, 1'b1);
      set_beat(1'b1, base + 32'(i), i == len, 2'b00);
      settle();
      n_checks++; if (s_rvalid(p) !== 1'b1) begin n_fail++; $display("FAIL beat_rvalid: beat %0d got %b want 1", i, s_rvalid(p)); end
      n_checks++; if (s_rdata(p) !== base + 32'(i)) begin n_fail++; $display("FAIL beat_rdata: got %h want %h", s_rdata(p), base + 32'(i)); end
      n_checks++; if (s_rlast(p) !== (i == len)) begin n_fail++; $display("FAIL beat_rlast: beat %0d got %b", i, s_rlast(p)); end
      n_checks++; if (s_rvalid(1 - p) !== 1'b0 || s_rdata(1 - p) !== 32'h0) begin n_fail++; $display("FAIL beat_other: rvalid %b rdata %h want 0/0", s_rvalid(1 - p), s_rdata(1 - p)); end
      n_checks++; if (m_if.rready !== 1'b1) begin n_fail++; $display("FAIL beat_m_rready: got %b want 1", m_if.rready); end
      cyc();
    end
    set_beat(1'b0, 32'h0, 1'b0, 2'b00);
    set_rready(p, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 1'b1, 32'hFFFF_FFFC, 4'hF, 3'h2);
    set_req(1, 1'b1, 32'h1234_5678, 4'h7, 3'h2);
    set_rready(0, 1'b1); set_rready(1, 1'b1);
    set_beat(1'b1, 32'hCAFE_F00D, 1'b1, 2'b10);
    m_if.arready = 1'b1;
    cyc();
    settle();
    check_all_quiet("rst_in");
    n_checks++; if (m_arburst !== 2'b01) begin n_fail++; $display("FAIL rst_arburst: got %b want 01", m_arburst); end
    n_checks++; if ({m_arid, m_arlock, m_arcache, m_arprot} !== 13'h0) begin n_fail++; $display("FAIL rst_consts: got %h want 0", {m_arid, m_arlock, m_arcache, m_arprot}); end
    n_checks++; if ({m_if.araddr, m_if.arlen, m_if.arsize} !== 39'h0) begin n_fail++; $display("FAIL rst_payload: got %h want 0", {m_if.araddr, m_if.arlen, m_if.arsize}); end
    idle_inputs();
    rst = 1'b0;
    settle();
    check_all_quiet("rst_after");
    cyc();
    check_all_quiet("rst_after2");
  endtask

  task automatic test_single_dcache();
    int w;
    do_reset();
    set_req(0, 1'b1, 32'h1FC0_0000, 4'd3, 3'd2);
    settle();
    n_checks++; if (m_if.arvalid !== 1'b0 || s0_if.arready !== 1'b0) begin n_fail++; $display("FAIL single_idle: m_arvalid %b s0_arready %b want 0/0", m_if.arvalid, s0_if.arready); end
    wait_ar(0, 32'h1FC0_0000, 4'd3, w);
    n_checks++; if (w != 1) begin n_fail++; $display("FAIL single_latency: got %0d want 1", w); end
    serve_beats(0, 3, 32'h0000_0100);
    set_beat(1'b1, 32'hDEAD_BEEF, 1'b1, 2'b00);
    set_rready(0, 1'b1);
    settle();
    check_all_quiet("single_stray");
    cyc();
    check_all_quiet("single_stray2");
    idle_inputs();
  endtask

  task automatic test_both_from_reset();
    int w;
    do_reset();
    set_req(0, 1'b1, 32'h0000_4000, 4'd1, 3'd2);
    set_req(1, 1'b1, 32'h8000_0040, 4'd2, 3'd2);
    wait_ar(0, 32'h0000_4000, 4'd1, w);
    serve_beats(0, 1, 32'h0000_0200);
    wait_ar(1, 32'h8000_0040, 4'd2, w);
    n_checks++; if (w != 1) begin n_fail++; $display("FAIL both_gap: got %0d want 1", w); end
    serve_beats(1, 2, 32'h0000_0300);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int w;
    logic [31:0] a [2];
    do_reset();
    a[0] = 32'h0000_1000;
    a[1] = 32'h0000_2000;
    set_req(0, 1'b1, a[0], 4'd1, 3'd2);
    set_req(1, 1'b1, a[1], 4'd1, 3'd2);
    for (int k = 0; k < 3; k++) begin
      int e;
      e = (k == 1) ? 1 : 0;
      wait_ar(e, a[e], 4'd1, w);
      n_checks++; if (w != 1) begin n_fail++; $display("FAIL b2b_gap: burst %0d got %0d idle cycles want 1", k, w); end
      a[e] = a[e] + 32'h40;
      set_req(e, 1'b1, a[e], 4'd1, 3'd2);
      serve_beats(e, 1, 32'h0000_B000 + 32'(k * 16));
    end
    idle_inputs();
  endtask

  task automatic test_arready_stall();
    int w;
    do_reset();
    set_req(0, 1'b1, 32'h0000_2000, 4'd2, 3'd2);
    cyc();
    for (int i = 0; i < 5; i++) begin
      m_if.arready = 1'b0;
      set_beat(1'b1, 32'h5555_0000, 1'b0, 2'b00);
      set_rready(0, 1'b1);
      settle();
      n_checks++; if (m_if.arvalid !== 1'b1) begin n_fail++; $display("FAIL stall_arvalid: cycle %0d got %b want 1", i, m_if.arvalid); end
      n_checks++; if (m_if.araddr !== 32'h0000_2000 || m_if.arlen !== 4'd2) begin n_fail++; $display("FAIL stall_payload: got %h/%0d want 00002000/2", m_if.araddr, m_if.arlen); end
      n_checks++; if (s0_if.arready !== 1'b0) begin n_fail++; $display("FAIL stall_s0_arready: got %b want 0", s0_if.arready); end
      n_checks++; if (m_if.rready !== 1'b0 || s0_if.rvalid !== 1'b0) begin n_fail++; $display("FAIL stall_rbeat: m_rready %b s0_rvalid %b want 0/0", m_if.rready, s0_if.rvalid); end
      cyc();
    end
    set_beat(1'b0, 32'h0, 1'b0, 2'b00);
    set_rready(0, 1'b0);
    wait_ar(0, 32'h0000_2000, 4'd2, w);
    n_checks++; if (w != 0) begin n_fail++; $display("FAIL stall_6th: waited %0d want 0", w); end
    serve_beats(0, 2, 32'h0000_0400);
    idle_inputs();
  endtask

  task automatic test_r_backpressure();
    int w;
    int idx;
    logic rr;
    logic [31:0] rx [$];
    do_reset();
    set_req(1, 1'b1, 32'h0000_3000, 4'd3, 3'd2);
    wait_ar(1, 32'h0000_3000, 4'd3, w);
    idx = 0;
    for (int c = 0; c < 20 && idx <= 3; c++) begin
      rr = (c % 2 == 0);
      set_rready(1, rr);
      set_beat(1'b1, 32'hA0 + 32'(idx), idx == 3, 2'b00);
      settle();
      n_checks++; if (m_if.rready !== rr) begin n_fail++; $display("FAIL bp_m_rready: cycle %0d got %b want %b", c, m_if.rready, rr); end
      if (s1_if.rvalid === 1'b1 && rr) rx.push_back(s1_if.rdata);
      cyc();
      if (rr) idx++;
    end
    n_checks++; if (rx.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d beats want 4", rx.size()); end
    for (int i = 0; i < rx.size() && i < 4; i++) begin
      n_checks++; if (rx[i] !== 32'hA0 + 32'(i)) begin n_fail++; $display("FAIL bp_data: beat %0d got %h want %h", i, rx[i], 32'hA0 + 32'(i)); end
    end
    set_rready(1, 1'b1);
    set_beat(1'b1, 32'hA4, 1'b1, 2'b00);
    settle();
    check_all_quiet("bp_after");
    idle_inputs();
  endtask

  task automatic test_reset_mid_data();
    int w;
    do_reset();
    set_req(0, 1'b1, 32'h0000_5000, 4'd3, 3'd2);
    wait_ar(0, 32'h0000_5000, 4'd3, w);
    for (int i = 0; i < 2; i++) begin
      set_rready(0, 1'b1);
      set_beat(1'b1, 32'h600 + 32'(i), 1'b0, 2'b00);
      cyc();
    end
    set_beat(1'b1, 32'h602, 1'b0, 2'b00);
    settle();
    n_checks++; if (m_if.rready !== 1'b1 || s0_if.rvalid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: m_rready %b s0_rvalid %b want 1/1", m_if.rready, s0_if.rvalid); end
    rst = 1'b1;
    settle();
    check_all_quiet("midrst");
    idle_inputs();
    cyc();
    rst = 1'b0;
    set_req(0, 1'b1, 32'h0000_7000, 4'd0, 3'd2);
    set_req(1, 1'b1, 32'h0000_8000, 4'd0, 3'd2);
    wait_ar(0, 32'h0000_7000, 4'd0, w);
    serve_beats(0, 0, 32'h0000_0700);
    idle_inputs();
  endtask

  task automatic test_random(int n);
    logic [31:0] q_addr [2];
    logic [3:0]  q_len [2];
    logic [2:0]  q_size [2];
    bit          pend [2];
    bit          rr [2];
    int          rx [2];
    int          ex [2];
    int          phase, nxt, g, prev, beat, burst_no;
    logic [31:0] c_addr;
    logic [3:0]  c_len;
    logic [2:0]  c_size;
    int          bus_left, bus_beat, bus_no;
    bit          bus_rv;
    bit          done;
    logic        exp_b;
    logic [31:0] exp_d;
    logic [31:0] want;
    do_reset();
    phase = 0; g = 0; prev = 1; beat = 0; burst_no = 0;
    c_addr = 32'h0; c_len = 4'h0; c_size = 3'h0;
    bus_left = 0; bus_beat = 0; bus_no = 0; bus_rv = 1'b0; done = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; rx[p] = 0; ex[p] = 0; rr[p] = 1'b0;
      q_addr[p] = 32'h0; q_len[p] = 4'h0; q_size[p] = 3'h0;
    end
    for (int c = 0; c < n + 400 && !done; c++) begin
      if (c >= n && phase == 0 && !pend[0] && !pend[1]) begin
        done = 1'b1;
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (!pend[p] && c < n && $urandom_range(0, 2) == 0) begin
            pend[p] = 1'b1;
            q_addr[p] = $urandom & 32'hFFFF_FFFC;
            q_len[p] = 4'($urandom_range(0, 5));
            q_size[p] = 3'($urandom_range(0, 2));
          end
          set_req(p, pend[p], q_addr[p], q_len[p], q_size[p]);
          rr[p] = 1'($urandom_range(0, 1));
          set_rready(p, rr[p]);
        end
        m_if.arready = 1'($urandom_range(0, 1));
        m_rid = 4'($urandom);
        if (bus_left > 0 && !bus_rv) bus_rv = ($urandom_range(0, 2) != 0);
        if (bus_rv) set_beat(1'b1, {8'(bus_no), 8'(bus_beat), 16'h5A00 ^ 16'(bus_beat)}, bus_left == 1, 2'(bus_beat));
        else        set_beat(1'b0, $urandom, 1'($urandom_range(0, 1)), 2'($urandom));
        settle();

        exp_b = (phase == 1);
        n_checks++; if (m_if.arvalid !== exp_b) begin n_fail++; $display("FAIL rnd_arvalid: cycle %0d got %b want %b", c, m_if.arvalid, exp_b); end
        if (phase == 1) begin
          n_checks++;
          if ({m_arid, m_if.araddr, m_if.arlen, m_if.arsize} !== {4'(g), c_addr, c_len, c_size}) begin
            n_fail++; $display("FAIL rnd_ar_payload: cycle %0d got id %0d addr %h len %0d want id %0d addr %h len %0d", c, m_arid, m_if.araddr, m_if.arlen, g, c_addr, c_len);
          end
        end
        for (int p = 0; p < 2; p++) begin
          exp_b = (phase == 1 && g == p) ? m_if.arready : 1'b0;
          n_checks++; if (s_arready(p) !== exp_b) begin n_fail++; $display("FAIL rnd_arready: cycle %0d port %0d got %b want %b", c, p, s_arready(p), exp_b); end
          exp_b = (phase == 2 && g == p) ? m_if.rvalid : 1'b0;
          exp_d = (phase == 2 && g == p) ? m_if.rdata : 32'h0;
          n_checks++; if (s_rvalid(p) !== exp_b || s_rdata(p) !== exp_d) begin n_fail++; $display("FAIL rnd_route: cycle %0d port %0d got %b/%h want %b/%h", c, p, s_rvalid(p), s_rdata(p), exp_b, exp_d); end
        end
        exp_b = (phase == 2) ? rr[g] : 1'b0;
        n_checks++; if (m_if.rready !== exp_b) begin n_fail++; $display("FAIL rnd_m_rready: cycle %0d got %b want %b", c, m_if.rready, exp_b); end

        if (phase == 2 && rr[g] && s_rvalid(g) === 1'b1) begin
          want = {8'(burst_no), 8'(beat), 16'h5A00 ^ 16'(beat)};
          n_checks++; if (s_rdata(g) !== want || s_rresp(g) !== 2'(beat)) begin n_fail++; $display("FAIL rnd_beat_data: got %h/%0d want %h/%0d", s_rdata(g), s_rresp(g), want, beat); end
          n_checks++; if (s_rlast(g) !== (beat == int'(c_len))) begin n_fail++; $display("FAIL rnd_beat_last: beat %0d of len %0d got %b", beat, c_len, s_rlast(g)); end
          rx[g]++;
        end

        nxt = phase;
        case (phase)
          0: if (pend[0] || pend[1]) begin
               g = (pend[0] && pend[1]) ? 1 - prev : (pend[1] ? 1 : 0);
               prev = g;
               c_addr = q_addr[g]; c_len = q_len[g]; c_size = q_size[g];
               nxt = 1;
             end
          1: if (m_if.arready) begin
               pend[g] = 1'b0;
               burst_no++;
               beat = 0;
               ex[g] += int'(c_len) + 1;
               nxt = 2;
             end
          default: if (bus_rv && rr[g]) begin
               if (beat == int'(c_len)) nxt = 0;
               beat++;
             end
        endcase

        if (m_if.arvalid === 1'b1 && m_if.arready) begin
          bus_left = int'(m_if.arlen) + 1; bus_beat = 0; bus_no++;
        end else if (bus_rv && m_if.rready === 1'b1) begin
          bus_rv = 1'b0; bus_beat++; bus_left--;
        end
        phase = nxt;
        cyc();
      end
    end
    n_checks++; if (!done) begin n_fail++; $display("FAIL rnd_drain: traffic did not drain, phase %0d", phase); end
    for (int p = 0; p < 2; p++) begin
      n_checks++; if (rx[p] != ex[p]) begin n_fail++; $display("FAIL rnd_beat_count: port %0d got %0d beats want %0d", p, rx[p], ex[p]); end
    end
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_dcache();
    test_both_from_reset();
    test_back_to_back();
    test_arready_stall();
    test_r_backpressure();
    test_reset_mid_data();
    test_random(2000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
